// File: rtl/clock_supervisor.sv
`default_nettype none
//==============================================================================
// Module   : clock_supervisor
// Brief    : Supervises a DCM from the free-running reference clock. It pulses
//            the DCM reset, waits for LOCKED, requires a stable settle window
//            before releasing the system reset, and restarts the DCM on any
//            lock loss. Optional retry limit (CLOCK_SUPERVISOR_RETRY_LIMIT_EN)
//            parks the block in FAIL after MAX_RETRIES consecutive timeouts.
// Revision : 1.0 - initial release
//==============================================================================
module clock_supervisor #(
   parameter int DCM_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 200000,
   parameter int SETTLE_CYCLES  = 2048,
   parameter int MAX_RETRIES    = 8
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       clk_locked,
   output logic       dcm_rstn,
   output logic       sys_rstn,
   output logic [7:0] lost_cnt,
   output logic [2:0] state_o,
   output logic       fail
);

   // Counter widths; a parameter of 1 still needs a 1-bit counter.
   localparam int RST_W = (DCM_RST_CYCLES > 1) ? $clog2(DCM_RST_CYCLES) : 1;
   localparam int TO_W  = (LOCK_TIMEOUT   > 1) ? $clog2(LOCK_TIMEOUT)   : 1;
   localparam int SET_W = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;

   localparam logic [RST_W-1:0] RST_LAST = RST_W'(DCM_RST_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_DCMRST   = 3'd0,
      ST_WAITLOCK = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_RUN      = 3'd3,
      ST_FAIL     = 3'd4
   } state_t;

   state_t           state_q,    state_d;
   logic [RST_W-1:0] rst_cnt_q,  rst_cnt_d;
   logic [TO_W-1:0]  to_cnt_q,   to_cnt_d;
   logic [SET_W-1:0] set_cnt_q,  set_cnt_d;
   logic [7:0]       lost_cnt_q, lost_cnt_d;
   logic             lock_meta_q;
   logic             lock_s_q;
   logic             w_timeout;
   logic             w_to_exp;
   logic [TO_W-1:0]  w_to_next;

`ifdef CLOCK_SUPERVISOR_RETRY_LIMIT_EN
   localparam int RTY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
   localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);
   logic [RTY_W-1:0] retry_q, retry_d;
`endif

   // Two-flop synchronizer for the asynchronous LOCKED input.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= clk_locked;
         lock_s_q    <= lock_meta_q;
      end
   end

   // The timeout counter measures time since DCM reset release; it runs
   // through both WAITLOCK and SETTLE and parks at its last value.
   assign w_to_exp  = (to_cnt_q == TO_LAST);
   assign w_to_next = w_to_exp ? to_cnt_q : to_cnt_q + 1'b1;

   // Next-state and counter logic.
   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      to_cnt_d   = to_cnt_q;
      set_cnt_d  = set_cnt_q;
      lost_cnt_d = lost_cnt_q;
      w_timeout  = 1'b0;
`ifdef CLOCK_SUPERVISOR_RETRY_LIMIT_EN
      retry_d    = retry_q;
`endif
      case (state_q)
         ST_DCMRST: begin
            to_cnt_d  = '0;
            set_cnt_d = '0;
            if (rst_cnt_q == RST_LAST) begin
               rst_cnt_d = '0;
               state_d   = ST_WAITLOCK;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         ST_WAITLOCK: begin
            to_cnt_d = w_to_next;
            if (lock_s_q) begin
               // Lock takes priority over a timeout in the same cycle.
               state_d   = ST_SETTLE;
               set_cnt_d = '0;
            end else if (w_to_exp) begin
               w_timeout = 1'b1;
            end
         end
         ST_SETTLE: begin
            to_cnt_d = w_to_next;
            if (lock_s_q) begin
               if (set_cnt_q == SET_LAST) begin
                  state_d = ST_RUN;
`ifdef CLOCK_SUPERVISOR_RETRY_LIMIT_EN
                  retry_d = '0;
`endif
               end else begin
                  set_cnt_d = set_cnt_q + 1'b1;
               end
            end else begin
               set_cnt_d = '0;
               // A drop after the deadline has passed counts as a timeout:
               // lock was never held stably within the allowed window.
               if (w_to_exp) begin
                  w_timeout = 1'b1;
               end else begin
                  state_d = ST_WAITLOCK;
               end
            end
         end
         ST_RUN: begin
            if (!lock_s_q) begin
               state_d = ST_DCMRST;
               if (lost_cnt_q != 8'hFF) begin
                  lost_cnt_d = lost_cnt_q + 8'd1;
               end
            end
         end
         ST_FAIL: begin
            state_d = ST_FAIL;
         end
         default: begin
            state_d = ST_DCMRST;
         end
      endcase

      if (w_timeout) begin
`ifdef CLOCK_SUPERVISOR_RETRY_LIMIT_EN
         if (retry_q == RTY_LAST) begin
            state_d = ST_FAIL;
         end else begin
            state_d = ST_DCMRST;
            retry_d = retry_q + 1'b1;
         end
`else
         state_d = ST_DCMRST;
`endif
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_DCMRST;
         rst_cnt_q  <= '0;
         to_cnt_q   <= '0;
         set_cnt_q  <= '0;
         lost_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         rst_cnt_q  <= rst_cnt_d;
         to_cnt_q   <= to_cnt_d;
         set_cnt_q  <= set_cnt_d;
         lost_cnt_q <= lost_cnt_d;
      end
   end

`ifdef CLOCK_SUPERVISOR_RETRY_LIMIT_EN
   // Consecutive-timeout counter.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         retry_q <= '0;
      end else begin
         retry_q <= retry_d;
      end
   end

   assign fail = (state_q == ST_FAIL);
`else
   // MAX_RETRIES has no effect in this build; it is referenced here so the
   // parameter list stays identical across both builds.
   if (MAX_RETRIES < 1) begin : g_retry_cfg_ignored
   end

   assign fail = 1'b0;
`endif

   // Outputs are decoded from the state register only.
   assign dcm_rstn = (state_q != ST_DCMRST) && (state_q != ST_FAIL);
   assign sys_rstn = (state_q == ST_RUN);
   assign lost_cnt = lost_cnt_q;
   assign state_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_supervisor.sv
`default_nettype none
//==============================================================================
// Module   : tb_clock_supervisor
// Brief    : Directed self-checking bench for clock_supervisor. Edge numbers
//            in the comments count rising edges from the first edge that
//            samples rstn=1 (E1).
// Revision : 1.0 - initial release
//==============================================================================
module tb_clock_supervisor;

   logic       clk;
   logic       rstn;
   logic       clk_locked;
   logic       dcm_rstn;
   logic       sys_rstn;
   logic [7:0] lost_cnt;
   logic [2:0] state_o;
   logic       fail;

   int n_checks = 0;
   int n_fail   = 0;
   bit saw_run;

   clock_supervisor #(
      .DCM_RST_CYCLES (4),
      .LOCK_TIMEOUT   (100),
      .SETTLE_CYCLES  (10),
      .MAX_RETRIES    (3)
   ) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .clk_locked (clk_locked),
      .dcm_rstn   (dcm_rstn),
      .sys_rstn   (sys_rstn),
      .lost_cnt   (lost_cnt),
      .state_o    (state_o),
      .fail       (fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_state"}, 32'(state_o), 32'd0);
      check_eq({tag, "_dcm"},   32'(dcm_rstn), 32'd0);
      check_eq({tag, "_sys"},   32'(sys_rstn), 32'd0);
      check_eq({tag, "_lost"},  32'(lost_cnt), 32'd0);
      check_eq({tag, "_fail"},  32'(fail),     32'd0);
   endtask

   initial begin
      rstn       = 1'b0;
      clk_locked = 1'b0;
      step(3);
      check_reset_state("por");

      // Lock present from the start: DCMRST E1..E3, WAITLOCK at E4,
      // SETTLE at E5, RUN at E15.
      clk_locked = 1'b1;
      step(2);
      rstn = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         step(1);
         if (k <= 4)  check_eq("dwell_dcm", 32'(dcm_rstn), (k == 4) ? 32'd1 : 32'd0);
         if (k == 5)  check_eq("const_settle", 32'(state_o), 32'd2);
         if (k == 14) check_eq("const_sys_pre", 32'(sys_rstn), 32'd0);
         if (k == 15) begin
            check_eq("const_sys_run", 32'(sys_rstn), 32'd1);
            check_eq("const_state_run", 32'(state_o), 32'd3);
         end
      end
      check_eq("const_lost", 32'(lost_cnt), 32'd0);

      // Lock rises after WAITLOCK entry: first sample at E7, RUN at E19.
      rstn       = 1'b0;
      clk_locked = 1'b0;
      step(1);
      rstn = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         if (k == 7) clk_locked = 1'b1;
         step(1);
         if (k == 4)  check_eq("late_waitlock", 32'(state_o), 32'd1);
         if (k == 18) check_eq("late_sys_pre", 32'(sys_rstn), 32'd0);
         if (k == 19) check_eq("late_sys_run", 32'(sys_rstn), 32'd1);
      end

      // One-cycle lock loss sampled at edge B; DCMRST from B+2 to B+5.
      clk_locked = 1'b0;
      step(1);
      check_eq("loss_b0_state", 32'(state_o), 32'd3);
      clk_locked = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         step(1);
         if (k == 1) check_eq("loss_b1_dcm", 32'(dcm_rstn), 32'd1);
         if (k == 2) begin
            check_eq("loss_b2_state", 32'(state_o), 32'd0);
            check_eq("loss_b2_dcm", 32'(dcm_rstn), 32'd0);
            check_eq("loss_b2_sys", 32'(sys_rstn), 32'd0);
            check_eq("loss_b2_lost", 32'(lost_cnt), 32'd1);
         end
         if (k == 5) check_eq("loss_b5_dcm", 32'(dcm_rstn), 32'd0);
         if (k == 6) check_eq("loss_b6_dcm", 32'(dcm_rstn), 32'd1);
         if (k == 17) check_eq("loss_b17_run", 32'(state_o), 32'd3);
      end
      for (int i = 0; i < 299; i++) begin
         clk_locked = 1'b0;
         step(1);
         clk_locked = 1'b1;
         step(17);
         if (i == 0) check_eq("loss_lost2", 32'(lost_cnt), 32'd2);
      end
      check_eq("loss_lost_sat", 32'(lost_cnt), 32'd255);
      check_eq("loss_final_run", 32'(state_o), 32'd3);

      // Reset while in RUN.
      rstn = 1'b0;
      step(1);
      check_reset_state("rst_run");

      // No lock at all: timeouts at E104, E208, E312.
      clk_locked = 1'b0;
      rstn       = 1'b1;
      for (int k = 1; k <= 416; k++) begin
         step(1);
         if (k == 103) check_eq("to1_pre", 32'(state_o), 32'd1);
         if (k == 104) check_eq("to1_dcmrst", 32'(state_o), 32'd0);
         if (k == 107) check_eq("to1_dwell", 32'(state_o), 32'd0);
         if (k == 108) check_eq("to1_wait", 32'(state_o), 32'd1);
         if (k == 207) check_eq("to2_pre", 32'(state_o), 32'd1);
         if (k == 208) check_eq("to2_dcmrst", 32'(state_o), 32'd0);
         if (k == 311) check_eq("to3_pre", 32'(state_o), 32'd1);
`ifdef CLOCK_SUPERVISOR_RETRY_LIMIT_EN
         if (k == 312) begin
            check_eq("to3_fail_state", 32'(state_o), 32'd4);
            check_eq("to3_fail_flag", 32'(fail), 32'd1);
            check_eq("to3_fail_dcm", 32'(dcm_rstn), 32'd0);
            check_eq("to3_fail_sys", 32'(sys_rstn), 32'd0);
         end
         if (k == 416) check_eq("fail_hold", 32'(state_o), 32'd4);
`else
         if (k == 312) begin
            check_eq("to3_dcmrst", 32'(state_o), 32'd0);
            check_eq("to3_fail_flag", 32'(fail), 32'd0);
         end
         if (k == 416) check_eq("to4_dcmrst", 32'(state_o), 32'd0);
`endif
      end

      // Reset while in FAIL (or in the timeout cycle without the limit).
      rstn = 1'b0;
      step(1);
      check_reset_state("rst_fail");

      // Lock pattern 5 on / 1 off; synchronized zeros at E15+6m always land
      // in SETTLE. Deadline passes at E104; first drop after it at E105.
      rstn    = 1'b1;
      saw_run = 1'b0;
      for (int k = 1; k <= 105; k++) begin
         clk_locked = (k >= 8) && (((k - 8) % 6) != 5);
         step(1);
         if (state_o == 3'd3) saw_run = 1'b1;
         if (k == 10)  check_eq("tog_settle", 32'(state_o), 32'd2);
         if (k == 15)  check_eq("tog_back_wait", 32'(state_o), 32'd1);
         if (k == 104) check_eq("tog_pre_to", 32'(state_o), 32'd2);
         if (k == 105) begin
            check_eq("tog_timeout", 32'(state_o), 32'd0);
            check_eq("tog_timeout_dcm", 32'(dcm_rstn), 32'd0);
         end
      end
      check_eq("tog_never_run", 32'(saw_run), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clock_supervisor.md
CLOCK_SUPERVISOR -- requirements
Module: clock_supervisor

Interface
REQ-001 SHALL have parameter DCM_RST_CYCLES, default 16: number of cycles dcm_rstn is held low per DCM reset.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 200000: cycles allowed from DCM reset release to first lock (1 ms at 200 MHz).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 2048: consecutive locked cycles required before system reset release.
REQ-004 SHALL have parameter MAX_RETRIES, default 8: consecutive lock timeouts tolerated; used only under CLOCK_SUPERVISOR_RETRY_LIMIT_EN.
REQ-005 SHALL have port clk, input, 1 bit: free-running 200 MHz oscillator-derived clock (clk_refiod net), never the DCM output.
REQ-006 SHALL have port rstn, input, 1 bit: synchronous active-low reset, sampled on rising clk.
REQ-007 SHALL have port clk_locked, input, 1 bit: DCM LOCKED, asynchronous to clk.
REQ-008 SHALL have port dcm_rstn, output, 1 bit: active-low DCM reset request, connected to the clock unit rstn.
REQ-009 SHALL have port sys_rstn, output, 1 bit: active-low reset for logic clocked by the DCM clocks.
REQ-010 SHALL have port lost_cnt, output, 8 bits: count of lock losses while running.
REQ-011 SHALL have port state_o, output, 3 bits: encoded FSM state (DCMRST=0, WAITLOCK=1, SETTLE=2, RUN=3, FAIL=4).
REQ-012 SHALL have port fail, output, 1 bit: permanent lock failure flag.

Function
REQ-013 SHALL synchronize clk_locked through two flip-flops; lock_s is the second stage; all decisions use lock_s only.
REQ-014 SHALL drive dcm_rstn=0 exactly while state==DCMRST and sys_rstn=1 exactly while state==RUN, both decoded from the state register.
REQ-015 DCMRST: SHALL stay exactly DCM_RST_CYCLES cycles, then go to WAITLOCK with timeout counter cleared.
REQ-016 WAITLOCK: lock_s=1 -> SETTLE with settle counter cleared; else timeout counter reaching LOCK_TIMEOUT-1 -> DCMRST and retry counter +1.
REQ-017 WAITLOCK: lock_s=1 in the same cycle the timeout expires SHALL take SETTLE (lock wins).
REQ-018 SETTLE: each cycle with lock_s=1 increments the settle counter; counter at SETTLE_CYCLES-1 with lock_s=1 -> RUN and retry counter cleared.
REQ-019 SETTLE: lock_s=0 -> WAITLOCK, settle counter cleared, timeout counter NOT cleared (continues from DCMRST exit).
REQ-020 RUN: lock_s=0 -> DCMRST in the next cycle and lost_cnt +1, saturating at 255.
REQ-021 SHALL size counters to $clog2 of their parameter; no counter wraps.

Reset
REQ-022 rstn=0 at any clock edge, in any state, SHALL force state DCMRST, all counters and both synchronizer stages 0, lost_cnt=0, fail=0; hence dcm_rstn=0, sys_rstn=0.
REQ-023 After rstn rises, the DCMRST dwell of REQ-015 SHALL start counting from the first edge with rstn=1.

Configuration
REQ-024 With CLOCK_SUPERVISOR_RETRY_LIMIT_EN defined: a timeout that brings the retry counter to MAX_RETRIES SHALL go to FAIL instead of DCMRST; FAIL holds dcm_rstn=0, sys_rstn=0, fail=1 until rstn=0.
REQ-025 Without CLOCK_SUPERVISOR_RETRY_LIMIT_EN: retries are unlimited, FAIL is unreachable, fail is tied 0, no retry counter is built.

Verification (bench parameters DCM_RST_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=10, MAX_RETRIES=3)
REQ-026 Release rstn, clk_locked=1 from cycle 0 -> dcm_rstn low 4 cycles; sys_rstn rises 12 edges after the edge that first samples clk_locked=1 following WAITLOCK entry; lost_cnt=0.
REQ-027 In RUN, drop clk_locked for 1 cycle -> dcm_rstn low 4 cycles starting 3 edges later, sys_rstn=0, lost_cnt=1; repeat 300 times -> lost_cnt=255.
REQ-028 clk_locked held 0 -> DCMRST re-entered every 104 cycles; macro defined: after 3rd timeout state_o=4, fail=1; macro undefined: cycling continues indefinitely, fail=0.
REQ-029 clk_locked toggles 1 for 5 cycles, 0 for 1 cycle in SETTLE -> never reaches RUN; timeout at 100 cycles after DCMRST exit still fires.
REQ-030 Assert rstn=0 in RUN and in FAIL -> next edge state_o=0, dcm_rstn=0, sys_rstn=0, lost_cnt=0, fail=0.
